vram_access_arbiter: RTL
========================

// Module: vram_access_arbiter
// PURPOSE
//  Shares the single VRAM port between three requesters: BG fetch
//  (bg_addr), OBJ fetch, and the CPU bus.
//  - BG owns VRAM in active display, so the BG pipeline never stalls.
//  - OBJ takes leftover cycles; CPU gets blanking time plus a bounded-wait
//    guarantee.
//  - Sits between the BG/OBJ processing circuits, the CPU memory interface
//    and the VRAM macro (synchronous read, 1-cycle latency).
// PARAMETERS
//  ADDR_W        17  VRAM word address width
//  DATA_W        16  VRAM data width
//  MAX_CPU_WAIT  8   cycles of CPU waiting before CPU beats OBJ (>=1)
// PORTS
//  clock       in   1       system clock, all state on rising edge
//  rst_b       in   1       asynchronous active-low reset
//  hblank      in   1       horizontal blank (from display timing)
//  vblank      in   1       vertical blank (from display timing)
//  bg_req      in   1       BG read request this cycle
//  bg_addr     in   ADDR_W  BG read address
//  bg_rdata    out  DATA_W  BG read data
//  bg_rvalid   out  1       bg_rdata valid (1 cycle after BG grant)
//  obj_req     in   1       OBJ read request this cycle
//  obj_addr    in   ADDR_W  OBJ read address
//  obj_ack     out  1       OBJ request granted this cycle
//  obj_rdata   out  DATA_W  OBJ read data
//  obj_rvalid  out  1       obj_rdata valid
//  cpu_req     in   1       CPU access request, held until cpu_ack
//  cpu_we      in   1       1=write, 0=read; stable while cpu_req
//  cpu_addr    in   ADDR_W  CPU address; stable while cpu_req
//  cpu_wdata   in   DATA_W  CPU write data; stable while cpu_req
//  cpu_ack     out  1       CPU access granted this cycle (1-cycle pulse)
//  cpu_rdata   out  DATA_W  CPU read data
//  cpu_rvalid  out  1       cpu_rdata valid (reads only)
//  vram_addr   out  ADDR_W  VRAM address (combinational from grant)
//  vram_we     out  1       VRAM write strobe
//  vram_wdata  out  DATA_W  VRAM write data
//  vram_rdata  in   DATA_W  VRAM read data, 1 cycle after address
// BEHAVIOUR
//  - Reset: all registered outputs 0; rd_owner=NONE; cpu_wait=0.
//    Async assert, sync release.
//  - Each cycle, at most one requester is granted. vram_addr/we/wdata come
//    from the winner in the same cycle. With no winner: vram_addr=0, we=0.
//  - Priority by mode:
//    - ACTIVE (!hblank & !vblank): BG > OBJ > CPU.
//      If cpu_wait==MAX_CPU_WAIT: BG > CPU > OBJ.
//    - HBLANK (hblank & !vblank): BG > CPU > OBJ.
//    - VBLANK (vblank, hblank ignored): CPU > OBJ > BG.
//  - BG is never stalled in ACTIVE or HBLANK. bg_req has no ack; BG is
//    expected to request only in ACTIVE/HBLANK.
//  - cpu_wait: saturating counter.
//    - +1 each cycle cpu_req=1 and cpu_ack=0.
//    - Cleared on cpu_ack or when cpu_req=0.
//    - Never exceeds MAX_CPU_WAIT.
//  - CPU handshake:
//    - cpu_ack is combinational in the grant cycle; the access is done then.
//    - CPU must drop or change the request the cycle after ack. cpu_req
//      still high after ack is a new access.
//    - Writes: vram_we=1, vram_wdata=cpu_wdata in the ack cycle; no rvalid.
//  - rd_owner register FSM {NONE, BG, OBJ, CPU}:
//    - Loads the read winner each cycle; NONE for no grant or a CPU write.
//    - Next cycle: vram_rdata goes to that owner's rdata with its rvalid=1.
//    - Other rvalids 0; rdata of non-owners hold their last value.
//  - Read latency: request cycle N -> rvalid cycle N+1, every requester.
//  - Back-to-back grants to the same or different requesters are allowed
//    every cycle; no bubbles.
//  - Mode change mid-stream: priority uses the current cycle's blank
//    inputs. An in-flight read (rd_owner) still completes next cycle.
//  - Reset mid-access: in-flight read is dropped (no rvalid after release);
//    a held cpu_req is re-arbitrated from cpu_wait=0.
//  - Simultaneous bg_req & obj_req & cpu_req: exactly one ack/grant;
//    the losers see no ack.
// TESTING
//  - ACTIVE, bg_req=obj_req=cpu_req=1 every cycle, MAX_CPU_WAIT=8 ->
//    BG always granted. OBJ and CPU never ack; cpu_wait saturates at 8,
//    no overflow.
//  - ACTIVE, bg_req toggling 1,0,1,0 with obj_req=cpu_req=1 ->
//    OBJ wins idle slots until cpu_wait==8, then next idle slot goes to
//    CPU (cpu_ack=1), cpu_wait->0.
//  - VBLANK, CPU write addr 0x00100 data 0xBEEF then read 0x00100 ->
//    ack each; vram_we=1 on the first only; cpu_rvalid=1 with
//    cpu_rdata=0xBEEF the cycle after the second ack.
//  - HBLANK, bg_req=0, obj_req=cpu_req=1 -> CPU granted first; OBJ is
//    granted next cycle after cpu_req drops; obj_rvalid follows 1 cycle.
//  - Assert rst_b=0 the cycle after a BG read grant -> bg_rvalid stays 0
//    and all outputs are 0 during reset and the first cycle after release.

Source files
------------

// File: rtl/vram_access_arbiter.sv
// VRAM port arbiter: BG / OBJ / CPU share one synchronous-read VRAM port.
// Grant is combinational; read data is routed by a one-cycle owner tag.
module vram_access_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 16,
  parameter int MAX_CPU_WAIT = 8
) (
  input  logic              clock,
  input  logic              rst_b,
  input  logic              hblank,
  input  logic              vblank,
  input  logic              bg_req,
  input  logic [ADDR_W-1:0] bg_addr,
  output logic [DATA_W-1:0] bg_rdata,
  output logic              bg_rvalid,
  input  logic              obj_req,
  input  logic [ADDR_W-1:0] obj_addr,
  output logic              obj_ack,
  output logic [DATA_W-1:0] obj_rdata,
  output logic              obj_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [DATA_W-1:0] vram_wdata,
  input  logic [DATA_W-1:0] vram_rdata
);

  localparam int WW = $clog2(MAX_CPU_WAIT + 1);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_BG,
    OWN_OBJ,
    OWN_CPU
  } owner_t;

  owner_t rd_owner, rd_owner_nx;

  logic [WW-1:0] cpu_wait, cpu_wait_nx;
  logic          starve;
  logic          gnt_bg, gnt_obj, gnt_cpu;

  logic [DATA_W-1:0] bg_rdata_q, obj_rdata_q, cpu_rdata_q;

  assign starve = (cpu_wait == WW'(MAX_CPU_WAIT));

  always_comb begin
    gnt_bg  = 1'b0;
    gnt_obj = 1'b0;
    gnt_cpu = 1'b0;
    unique case (1'b1)
      vblank: begin
        gnt_cpu = cpu_req;
        gnt_obj = !cpu_req && obj_req;
        gnt_bg  = !cpu_req && !obj_req && bg_req;
      end
      // starved CPU is treated exactly like hblank priority
      (!vblank && (hblank || starve)): begin
        gnt_bg  = bg_req;
        gnt_cpu = !bg_req && cpu_req;
        gnt_obj = !bg_req && !cpu_req && obj_req;
      end
      default: begin
        gnt_bg  = bg_req;
        gnt_obj = !bg_req && obj_req;
        gnt_cpu = !bg_req && !obj_req && cpu_req;
      end
    endcase
  end

  always_comb begin
    vram_addr   = '0;
    vram_we     = 1'b0;
    vram_wdata  = '0;
    obj_ack     = gnt_obj;
    cpu_ack     = gnt_cpu;
    rd_owner_nx = OWN_NONE;
    if (gnt_bg) begin
      vram_addr   = bg_addr;
      rd_owner_nx = OWN_BG;
    end else if (gnt_obj) begin
      vram_addr   = obj_addr;
      rd_owner_nx = OWN_OBJ;
    end else if (gnt_cpu) begin
      vram_addr   = cpu_addr;
      vram_we     = cpu_we;
      vram_wdata  = cpu_we ? cpu_wdata : '0;
      rd_owner_nx = cpu_we ? OWN_NONE : OWN_CPU;
    end
  end

  always_comb begin
    cpu_wait_nx = '0;
    if (cpu_req && !gnt_cpu)
      cpu_wait_nx = starve ? cpu_wait : cpu_wait + WW'(1);
  end

  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      rd_owner <= OWN_NONE;
      cpu_wait <= '0;
    end else begin
      rd_owner <= rd_owner_nx;
      cpu_wait <= cpu_wait_nx;
    end
  end

  // read data lands one cycle after grant; non-owners hold last value
  assign bg_rvalid  = (rd_owner == OWN_BG);
  assign obj_rvalid = (rd_owner == OWN_OBJ);
  assign cpu_rvalid = (rd_owner == OWN_CPU);

  assign bg_rdata  = bg_rvalid  ? vram_rdata : bg_rdata_q;
  assign obj_rdata = obj_rvalid ? vram_rdata : obj_rdata_q;
  assign cpu_rdata = cpu_rvalid ? vram_rdata : cpu_rdata_q;

  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      bg_rdata_q  <= '0;
      obj_rdata_q <= '0;
      cpu_rdata_q <= '0;
    end else begin
      bg_rdata_q  <= bg_rdata;
      obj_rdata_q <= obj_rdata;
      cpu_rdata_q <= cpu_rdata;
    end
  end

endmodule
